// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker state encoding and the XNOR next-value
// function (XAPP052 tap table) reused by the generator and the checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  // Tap mask per width, bit n-1 set for XAPP052 tap n. Every entry has an
  // even tap count, so the all-ones word is the XNOR lock-up value.
  function automatic logic [31:0] f_lfsr_taps(input int unsigned width);
    case (width)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return '0;
    endcase
  endfunction

  // next(p) = {p[width-2:0], XNOR of taps}; result masked to width bits.
  function automatic logic [31:0] f_lfsr_next(input int unsigned width,
                                              input logic [31:0] value);
    logic [31:0] v_keep;
    logic        v_fb;
    v_fb   = ~^(value & f_lfsr_taps(width));
    v_keep = (width >= 32) ? '1 : ((32'h1 << width) - 32'h1);
    return ((value << 1) | {31'b0, v_fb}) & v_keep;
  endfunction

endpackage

// File: rtl/lfsr_next_word.sv
// Combinational next-word predictor for a NUM_BITS-wide XNOR LFSR.
module lfsr_next_word
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_BITS = 5
) (
  input  logic [NUM_BITS-1:0] i_Word,
  output logic [NUM_BITS-1:0] o_Next
);

  // Wrap the shared tap-table function at this width.
  always_comb begin
    o_Next = NUM_BITS'(f_lfsr_next(NUM_BITS, 32'(i_Word)));
  end

endmodule

// File: rtl/lfsr_sequence_checker.sv
// Locks onto an incoming XNOR-LFSR word stream, predicts each next word,
// flags and counts mismatches while locked, and marks each full period.
module lfsr_sequence_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_BITS     = 5,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned LOSS_COUNT   = 3,
  parameter int unsigned ERR_CNT_BITS = 16
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Data_DV,
  input  logic [NUM_BITS-1:0]     i_Data,
  input  logic                    i_Clear_Errors,
  output logic                    o_Locked,
  output logic                    o_Error,
  output logic                    o_Lock_Lost,
  output logic                    o_Period_Done,
  output logic [ERR_CNT_BITS-1:0] o_Error_Count
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_COUNT + 1);

  state_t                    r_state;
  logic [NUM_BITS-1:0]       r_ref;
  logic [NUM_BITS-1:0]       r_marker;
  logic [MATCH_W-1:0]        r_match_cnt;
  logic [MISS_W-1:0]         r_miss_cnt;
  logic                      r_locked;
  logic                      r_error;
  logic                      r_lost;
  logic                      r_period;
  logic [ERR_CNT_BITS-1:0]   r_err_cnt;

  logic [NUM_BITS-1:0]       w_pred;
  logic                      w_match;
  logic                      w_all_ones;
  logic                      w_count_err;

  lfsr_next_word #(
    .NUM_BITS (NUM_BITS)
  ) u_next (
    .i_Word (r_ref),
    .o_Next (w_pred)
  );

  assign w_match     = (i_Data == w_pred);
  assign w_all_ones  = (i_Data == '1);
  assign w_count_err = i_Data_DV && (r_state == LOCKED) && !w_match;

  // Search/verify/locked state machine with registered level and pulse outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state     <= SEARCH;
      r_ref       <= '0;
      r_marker    <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_lost      <= 1'b0;
      r_period    <= 1'b0;
    end else begin
      r_error  <= 1'b0;
      r_lost   <= 1'b0;
      r_period <= 1'b0;
      if (i_Data_DV) begin
        case (r_state)
          SEARCH: begin
            if (!w_all_ones) begin
              r_ref       <= i_Data;
              r_match_cnt <= '0;
              r_state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (w_match) begin
              r_ref <= i_Data;
              if (r_match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                r_state     <= LOCKED;
                r_locked    <= 1'b1;
                r_marker    <= i_Data;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + MATCH_W'(1);
              end
            end else if (w_all_ones) begin
              r_state     <= SEARCH;
              r_match_cnt <= '0;
            end else begin
              r_ref       <= i_Data;
              r_match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Free-run the reference from prediction so a single corrupt
            // word never poisons the following comparisons.
            r_ref    <= w_pred;
            r_period <= (w_pred == r_marker);
            if (w_match) begin
              r_miss_cnt <= '0;
            end else begin
              r_error <= 1'b1;
              if (r_miss_cnt == MISS_W'(LOSS_COUNT - 1)) begin
                r_state    <= SEARCH;
                r_locked   <= 1'b0;
                r_lost     <= 1'b1;
                r_miss_cnt <= '0;
              end else begin
                r_miss_cnt <= r_miss_cnt + MISS_W'(1);
              end
            end
          end
          default: begin
            r_state <= SEARCH;
          end
        endcase
      end
    end
  end

  // Saturating error counter; a clear coinciding with an error leaves one.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_err_cnt <= '0;
    end else if (i_Clear_Errors) begin
      r_err_cnt <= w_count_err ? ERR_CNT_BITS'(1) : '0;
    end else if (w_count_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_BITS'(1);
    end
  end

  assign o_Locked      = r_locked;
  assign o_Error       = r_error;
  assign o_Lock_Lost   = r_lost;
  assign o_Period_Done = r_period;
  assign o_Error_Count = r_err_cnt;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Directed bench for lfsr_sequence_checker (NUM_BITS=5), with a second
// instance using a 2-bit error counter for saturation checks.
module tb_lfsr_sequence_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv  = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] data = '0;

  logic        a_locked, a_error, a_lost, a_period;
  logic [15:0] a_count;
  logic        b_locked, b_error, b_lost, b_period;
  logic [1:0]  b_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned idx      = 0;
  int unsigned nvalid   = 0;

  // Hand-derived 5-bit XNOR sequence (taps 5,3) starting from 5'h00.
  logic [4:0] seq [31];

  always #5 clk = ~clk;

  lfsr_sequence_checker #(
    .NUM_BITS     (5),
    .LOCK_COUNT   (4),
    .LOSS_COUNT   (3),
    .ERR_CNT_BITS (16)
  ) dut_a (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Data_DV      (dv),
    .i_Data         (data),
    .i_Clear_Errors (clr),
    .o_Locked       (a_locked),
    .o_Error        (a_error),
    .o_Lock_Lost    (a_lost),
    .o_Period_Done  (a_period),
    .o_Error_Count  (a_count)
  );

  lfsr_sequence_checker #(
    .NUM_BITS     (5),
    .LOCK_COUNT   (4),
    .LOSS_COUNT   (3),
    .ERR_CNT_BITS (2)
  ) dut_b (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Data_DV      (dv),
    .i_Data         (data),
    .i_Clear_Errors (clr),
    .o_Locked       (b_locked),
    .o_Error        (b_error),
    .o_Lock_Lost    (b_lost),
    .o_Period_Done  (b_period),
    .o_Error_Count  (b_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: inputs set at negedge, outputs settle #1 after posedge.
  task automatic step(input logic v, input logic [4:0] w, input logic c);
    @(negedge clk);
    dv   = v;
    data = w;
    clr  = c;
    @(posedge clk);
    #1;
    dv  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dv  = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_locked", a_locked, 0);
    check_eq("rst_error",  a_error,  0);
    check_eq("rst_lost",   a_lost,   0);
    check_eq("rst_period", a_period, 0);
    check_eq("rst_count",  a_count,  0);
    check_eq("rst_count_b", b_count, 0);
    rst    = 1'b0;
    idx    = 0;
    nvalid = 0;
  endtask

  task automatic idle_steps(input int unsigned gaps);
    for (int unsigned g = 0; g < gaps; g++) begin
      step(1'b0, 5'h00, 1'b0);
      check_eq("idle_error",  a_error,  0);
      check_eq("idle_period", a_period, 0);
    end
  endtask

  task automatic send_clean(input int unsigned gaps);
    idle_steps(gaps);
    step(1'b1, seq[idx % 31], 1'b0);
    idx++;
    nvalid++;
  endtask

  task automatic send_bad(input logic [4:0] flip, input logic c);
    step(1'b1, seq[idx % 31] ^ flip, c);
    idx++;
    nvalid++;
  endtask

  // Clean-stream expectations from reset: lock after word 5, period marker
  // is word 5 (value 5'h0E), recurring on words 36, 67, 98.
  task automatic check_clean_word();
    check_eq("locked",  a_locked, (nvalid >= 5) ? 1 : 0);
    check_eq("noerror", a_error, 0);
    check_eq("period",  a_period,
             ((nvalid >= 36) && ((nvalid - 36) % 31 == 0)) ? 1 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    seq = '{5'd0,  5'd1,  5'd3,  5'd7,  5'd14, 5'd28, 5'd25, 5'd18,
            5'd4,  5'd8,  5'd17, 5'd2,  5'd5,  5'd10, 5'd21, 5'd11,
            5'd23, 5'd15, 5'd30, 5'd29, 5'd27, 5'd22, 5'd13, 5'd26,
            5'd20, 5'd9,  5'd19, 5'd6,  5'd12, 5'd24, 5'd16};

    // Case 1: clean continuous stream.
    do_reset();
    for (int unsigned k = 0; k < 98; k++) begin
      send_clean(0);
      check_clean_word();
    end
    check_eq("c1_count", a_count, 0);

    // Case 2: single flipped bit while locked.
    send_bad(5'h01, 1'b0);
    check_eq("c2_error",  a_error,  1);
    check_eq("c2_count",  a_count,  1);
    check_eq("c2_locked", a_locked, 1);
    check_eq("c2_lost",   a_lost,   0);
    for (int unsigned k = 0; k < 3; k++) begin
      send_clean(0);
      check_eq("c2_after_error",  a_error,  0);
      check_eq("c2_after_locked", a_locked, 1);
    end

    // Clear alone zeroes the count.
    step(1'b0, 5'h00, 1'b1);
    check_eq("clear_alone", a_count, 0);

    // Case 3: three consecutive corrupt words drop lock, then relock.
    for (int unsigned k = 1; k <= 3; k++) begin
      send_bad(5'h10, 1'b0);
      check_eq("c3_error",  a_error,  1);
      check_eq("c3_count",  a_count,  k);
      check_eq("c3_lost",   a_lost,   (k == 3) ? 1 : 0);
      check_eq("c3_locked", a_locked, (k < 3) ? 1 : 0);
    end
    for (int unsigned k = 1; k <= 5; k++) begin
      send_clean(0);
      check_eq("c3_relock", a_locked, (k == 5) ? 1 : 0);
      check_eq("c3_lost_pulse", a_lost, 0);
      check_eq("c3_noerror", a_error, 0);
    end
    check_eq("c3_count_kept", a_count, 3);

    // Case 4: lock-up word stream never leaves SEARCH.
    do_reset();
    for (int unsigned k = 0; k < 10; k++) begin
      step(1'b1, 5'h1F, 1'b0);
      check_eq("c4_locked", a_locked, 0);
      check_eq("c4_error",  a_error,  0);
      check_eq("c4_lost",   a_lost,   0);
      check_eq("c4_period", a_period, 0);
    end

    // Case 5: saturation of the 2-bit counter, clear with coincident error.
    do_reset();
    for (int unsigned k = 0; k < 5; k++) send_clean(0);
    check_eq("c5_locked", b_locked, 1);
    for (int unsigned e = 1; e <= 5; e++) begin
      send_bad(5'h01, 1'b0);
      check_eq("c5_count_b", b_count, (e < 3) ? e : 3);
      check_eq("c5_count_a", a_count, e);
      send_clean(0);
      send_clean(0);
    end
    send_bad(5'h01, 1'b1);
    check_eq("c5_clr_err_b", b_count, 1);
    check_eq("c5_clr_err_a", a_count, 1);
    check_eq("c5_error_b",   b_error, 1);

    // Case 6: random DV gaps give the same results as case 1.
    do_reset();
    for (int unsigned k = 0; k < 70; k++) begin
      send_clean($urandom_range(0, 3));
      check_clean_word();
    end
    send_bad(5'h04, 1'b0);
    check_eq("c6_pre_rst_count", a_count, 1);
    // Reset while a valid word is presented: reset wins.
    @(negedge clk);
    rst  = 1'b1;
    dv   = 1'b1;
    data = seq[idx % 31];
    idx++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dv  = 1'b0;
    check_eq("c6_rst_locked", a_locked, 0);
    check_eq("c6_rst_error",  a_error,  0);
    check_eq("c6_rst_lost",   a_lost,   0);
    check_eq("c6_rst_period", a_period, 0);
    check_eq("c6_rst_count",  a_count,  0);
    for (int unsigned k = 1; k <= 5; k++) begin
      send_clean($urandom_range(0, 3));
      check_eq("c6_relock", a_locked, (k == 5) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
